// File: rtl/spart_bus_if.sv
// ---------------------------------------------------------------------------
// spart_bus_if
//   Control/status side of the SPART register bus.
//   iocs    chip select, one cycle per access
//   iorw    1 = read, 0 = write
//   ioaddr  00 tx/rx buffer, 01 status, 10 divisor low, 11 divisor high
//   rda     receive data available (SPART -> host)
//   tbr     transmit buffer ready  (SPART -> host)
//   The 8-bit databus is a tri-state net and stays a plain inout port on the
//   controller, so that every driver of it resolves at one hierarchy level.
// ---------------------------------------------------------------------------
interface spart_bus_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;

  modport master (output iocs, iorw, ioaddr, input rda, tbr);
  modport slave  (input iocs, iorw, ioaddr, output rda, tbr);
endinterface

// File: rtl/spart_bus_ctrl.sv
// ---------------------------------------------------------------------------
// spart_bus_ctrl
//   Host-side master of the SPART register bus. After reset it writes the
//   baud divisor selected by br_cfg (low byte, then high byte), then serves
//   received bytes (rda) and round-robin arbitrated transmit bytes from two
//   requesters (A, B) while tbr is high. Every access is one iocs cycle
//   followed by one idle GAP cycle.
// Ports
//   clk, rst         clock, asynchronous active-low reset
//   br_cfg           baud select, compared only while IDLE
//   req_a/data_a     requester A level request and byte; gnt_a 1-cycle grant
//   req_b/data_b     requester B, same rules; gnt_b 1-cycle grant
//   rx_data/rx_valid last byte read; rx_valid pulses once per byte
//   cfg_done         divisor programmed, bus in service
//   bus              iocs/iorw/ioaddr out, rda/tbr in
//   databus          driven only during writes, high-Z otherwise
// ---------------------------------------------------------------------------
module spart_bus_ctrl #(
  parameter logic [15:0] DIV_4800  = 16'h028A,
  parameter logic [15:0] DIV_9600  = 16'h0145,
  parameter logic [15:0] DIV_19200 = 16'h00A2,
  parameter logic [15:0] DIV_38400 = 16'h0050
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  br_cfg,
  input  logic        req_a,
  input  logic [7:0]  data_a,
  output logic        gnt_a,
  input  logic        req_b,
  input  logic [7:0]  data_b,
  output logic        gnt_b,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        cfg_done,
  spart_bus_if.master bus,
  inout  wire  [7:0]  databus
);

  typedef enum logic [2:0] {
    CFG_LO, CFG_HI, GAP, IDLE, RX_RD, TX_WR
  } state_t;

  localparam logic [1:0] A_BUF  = 2'b00;
  localparam logic [1:0] A_DBLO = 2'b10;
  localparam logic [1:0] A_DBHI = 2'b11;

  state_t      state_q;
  state_t      gap_ret_q;   // where GAP goes next: CFG_HI or IDLE
  logic [1:0]  cfg_q;       // br_cfg captured when CFG_LO was entered
  logic        iocs_q, iorw_q;
  logic [1:0]  addr_q;
  logic [7:0]  dout_q;
  logic        gnt_a_q, gnt_b_q;
  logic [7:0]  rx_data_q;
  logic        rx_valid_q;
  logic        cfg_done_q;
  logic        prefer_a_q;  // round-robin pointer: A wins the next tie

  logic [15:0] div_new, div_cur;
  logic        pick_b;

  function automatic logic [15:0] div_of(input logic [1:0] sel);
    unique case (sel)
      2'b00:   div_of = DIV_4800;
      2'b01:   div_of = DIV_9600;
      2'b10:   div_of = DIV_19200;
      default: div_of = DIV_38400;
    endcase
  endfunction

  assign div_new = div_of(br_cfg);
  assign div_cur = div_of(cfg_q);
  assign pick_b  = req_b && (!req_a || !prefer_a_q);

  // NOTE: every flop below, including the FSM state, sits on the async reset
  // so a mid-access reset releases the bus in the same instant, with no
  // clock required.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= CFG_LO;
      gap_ret_q  <= CFG_HI;
      cfg_q      <= 2'b00;
      iocs_q     <= 1'b0;
      iorw_q     <= 1'b1;
      addr_q     <= A_BUF;
      dout_q     <= 8'h00;
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      cfg_done_q <= 1'b0;
      prefer_a_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments throughout: these defaults are
      // overridden later in the same block, and all reads see the old values.
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
      rx_valid_q <= 1'b0;

      unique case (state_q)
        CFG_LO: begin
          if (!iocs_q) begin
            // Entered from reset with the bus idle: start the low-byte write.
            cfg_q  <= br_cfg;
            iocs_q <= 1'b1;
            iorw_q <= 1'b0;
            addr_q <= A_DBLO;
            dout_q <= div_new[7:0];
          end else begin
            iocs_q    <= 1'b0;
            iorw_q    <= 1'b1;
            addr_q    <= A_BUF;
            gap_ret_q <= CFG_HI;
            state_q   <= GAP;
          end
        end

        CFG_HI: begin
          iocs_q    <= 1'b0;
          iorw_q    <= 1'b1;
          addr_q    <= A_BUF;
          gap_ret_q <= IDLE;
          state_q   <= GAP;
        end

        RX_RD: begin
          rx_data_q  <= databus;
          rx_valid_q <= 1'b1;
          iocs_q     <= 1'b0;
          gap_ret_q  <= IDLE;
          state_q    <= GAP;
        end

        TX_WR: begin
          iocs_q    <= 1'b0;
          iorw_q    <= 1'b1;
          gap_ret_q <= IDLE;
          state_q   <= GAP;
        end

        GAP: begin
          if (gap_ret_q == CFG_HI) begin
            iocs_q  <= 1'b1;
            iorw_q  <= 1'b0;
            addr_q  <= A_DBHI;
            dout_q  <= div_cur[15:8];
            state_q <= CFG_HI;
          end else begin
            cfg_done_q <= 1'b1;
            state_q    <= IDLE;
          end
        end

        IDLE: begin
          if (br_cfg != cfg_q) begin
            cfg_q      <= br_cfg;
            cfg_done_q <= 1'b0;
            iocs_q     <= 1'b1;
            iorw_q     <= 1'b0;
            addr_q     <= A_DBLO;
            dout_q     <= div_new[7:0];
            state_q    <= CFG_LO;
          end else if (bus.rda) begin
            // Receive wins over transmit so the SPART rx buffer never overruns.
            iocs_q  <= 1'b1;
            iorw_q  <= 1'b1;
            addr_q  <= A_BUF;
            state_q <= RX_RD;
          end else if (bus.tbr && (req_a || req_b)) begin
            iocs_q  <= 1'b1;
            iorw_q  <= 1'b0;
            addr_q  <= A_BUF;
            state_q <= TX_WR;
            if (pick_b) begin
              dout_q     <= data_b;
              gnt_b_q    <= 1'b1;
              prefer_a_q <= 1'b1;
            end else begin
              dout_q     <= data_a;
              gnt_a_q    <= 1'b1;
              prefer_a_q <= 1'b0;
            end
          end
        end

        default: begin
          iocs_q  <= 1'b0;
          iorw_q  <= 1'b1;
          addr_q  <= A_BUF;
          state_q <= CFG_LO;
        end
      endcase
    end
  end

  assign bus.iocs   = iocs_q;
  assign bus.iorw   = iorw_q;
  assign bus.ioaddr = addr_q;
  assign databus    = (iocs_q && !iorw_q) ? dout_q : 8'hzz;
  assign gnt_a      = gnt_a_q;
  assign gnt_b      = gnt_b_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign cfg_done   = cfg_done_q;

endmodule

// File: tb/tb_spart_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spart_bus_ctrl
//   Register-level SPART model, two requester agents and a monitor that
//   checks every bus cycle against expected-value queues filled by the
//   stimulus side. Queues are arrays with a producer-owned write index and a
//   monitor-owned read index.
// ---------------------------------------------------------------------------
module tb_spart_bus_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] br_cfg = 2'b10;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic [7:0] data_a = 8'h00, data_b = 8'h00;
  logic       gnt_a, gnt_b, rx_valid, cfg_done;
  logic [7:0] rx_data;
  wire  [7:0] databus;
  logic [7:0] rx_hold = 8'h00;

  spart_bus_if bus();

  spart_bus_ctrl dut (
    .clk(clk), .rst(rst), .br_cfg(br_cfg),
    .req_a(req_a), .data_a(data_a), .gnt_a(gnt_a),
    .req_b(req_b), .data_b(data_b), .gnt_b(gnt_b),
    .rx_data(rx_data), .rx_valid(rx_valid), .cfg_done(cfg_done),
    .bus(bus), .databus(databus)
  );

  always #5 clk = ~clk;

  // SPART drives the buffer contents during any read cycle.
  assign databus = (bus.iocs && bus.iorw) ? rx_hold : 8'hzz;

  // ---------------- shared scoreboard storage ----------------
  logic [1:0] cfg_exp_addr [256];
  logic [7:0] cfg_exp_data [256];
  int         cfg_wr = 0, cfg_rd = 0;
  logic [7:0] src_a [64], src_b [64], rx_src [64];
  int         src_a_n = 0, src_b_n = 0, rx_src_n = 0;
  int         a_idx = 0, b_idx = 0, rx_idx = 0;
  logic [7:0] exp_a [64], exp_b [64], rx_exp [64];
  int         exp_a_wr = 0, exp_b_wr = 0, rx_exp_wr = 0;
  int         exp_a_rd = 0, exp_b_rd = 0, rx_exp_rd = 0;
  int         gap_max = 0;
  int         timeouts = 0;
  bit         done = 1'b0;
  int         errors = 0, checks = 0;

  function automatic logic [15:0] exp_div(input logic [1:0] c);
    case (c)
      2'b00:   return 16'h028A;
      2'b01:   return 16'h0145;
      2'b10:   return 16'h00A2;
      default: return 16'h0050;
    endcase
  endfunction

  // ---------------- SPART register model ----------------
  int tbr_cnt = 0, rx_wait = 0;
  initial begin
    bus.rda = 1'b0;
    bus.tbr = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.iocs && !bus.iorw && bus.ioaddr == 2'b00) begin
        bus.tbr = 1'b0;
        tbr_cnt = $urandom_range(1, 4);
      end else if (!bus.tbr) begin
        tbr_cnt--;
        if (tbr_cnt <= 0) bus.tbr = 1'b1;
      end
      if (bus.iocs && bus.iorw && bus.ioaddr == 2'b00) begin
        bus.rda = 1'b0;
      end else if (!bus.iocs && !bus.rda && rx_idx < rx_src_n) begin
        if (rx_wait == 0) begin
          rx_hold = rx_src[rx_idx];
          rx_exp[rx_exp_wr] = rx_hold;
          rx_exp_wr++;
          rx_idx++;
          bus.rda = 1'b1;
          rx_wait = $urandom_range(0, 6);
        end else begin
          rx_wait--;
        end
      end
    end
  end

  // ---------------- requester agents ----------------
  int gap_a = 0, gap_b = 0;
  initial forever begin
    @(posedge clk); #2;
    if (req_a && gnt_a) begin
      req_a = 1'b0;
      gap_a = $urandom_range(0, gap_max);
    end
    if (!req_a && a_idx < src_a_n) begin
      if (gap_a == 0) begin
        data_a = src_a[a_idx];
        a_idx++;
        exp_a[exp_a_wr] = data_a;
        exp_a_wr++;
        req_a = 1'b1;
      end else gap_a--;
    end
  end

  initial forever begin
    @(posedge clk); #2;
    if (req_b && gnt_b) begin
      req_b = 1'b0;
      gap_b = $urandom_range(0, gap_max);
    end
    if (!req_b && b_idx < src_b_n) begin
      if (gap_b == 0) begin
        data_b = src_b[b_idx];
        b_idx++;
        exp_b[exp_b_wr] = data_b;
        exp_b_wr++;
        req_b = 1'b1;
      end else gap_b--;
    end
  end

  // ---------------- monitor ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  bit iocs_prev, rd_prev, req_a_prev, req_b_prev, rda_prev, last_a, win_b, wr, rd;

  initial begin
    iocs_prev = 0; rd_prev = 0; req_a_prev = 0; req_b_prev = 0; rda_prev = 0; last_a = 0;
    while (!done) begin
      @(negedge clk or negedge rst);
      #1;
      if (!rst) begin
        check("rst_iocs", bus.iocs, 0);
        check("rst_iorw", bus.iorw, 1);
        check("rst_ioaddr", bus.ioaddr, 0);
        check("rst_gnt", {gnt_a, gnt_b}, 0);
        check("rst_rx", {rx_valid, rx_data}, 0);
        check("rst_cfg_done", cfg_done, 0);
        iocs_prev = 0; rd_prev = 0; last_a = 0;
        req_a_prev = req_a; req_b_prev = req_b; rda_prev = bus.rda;
        continue;
      end
      wr = bus.iocs && !bus.iorw;
      rd = bus.iocs && bus.iorw;
      if (iocs_prev) check("iocs_gap", bus.iocs, 0);
      if (wr && bus.ioaddr[1]) begin
        check("cfg_expected", cfg_rd < cfg_wr, 1);
        if (cfg_rd < cfg_wr) begin
          check("cfg_write", {bus.ioaddr, databus}, {cfg_exp_addr[cfg_rd], cfg_exp_data[cfg_rd]});
          cfg_rd++;
        end
        check("cfg_done_low", cfg_done, 0);
      end
      if (bus.iocs) check("no_status_addr", bus.ioaddr == 2'b01, 0);
      if (rd) check("rd_addr", bus.ioaddr, 0);
      if (wr && bus.ioaddr == 2'b00) begin
        check("tx_had_req", req_a_prev || req_b_prev, 1);
        check("tx_rx_priority", rda_prev, 0);
        check("tx_cfg_done", cfg_done, 1);
        win_b = req_b_prev && (!req_a_prev || last_a);
        check("tx_gnt", {gnt_a, gnt_b}, {!win_b, win_b});
        if (win_b) begin
          check("tx_b_expected", exp_b_rd < exp_b_wr, 1);
          if (exp_b_rd < exp_b_wr) begin
            check("tx_data_b", databus, exp_b[exp_b_rd]);
            exp_b_rd++;
          end
        end else begin
          check("tx_a_expected", exp_a_rd < exp_a_wr, 1);
          if (exp_a_rd < exp_a_wr) begin
            check("tx_data_a", databus, exp_a[exp_a_rd]);
            exp_a_rd++;
          end
        end
        last_a = !win_b;
      end else if (gnt_a || gnt_b) begin
        check("stray_gnt", {gnt_a, gnt_b}, 0);
      end
      if (rx_valid) begin
        check("rx_after_read", rd_prev, 1);
        check("rx_expected", rx_exp_rd < rx_exp_wr, 1);
        if (rx_exp_rd < rx_exp_wr) begin
          check("rx_data", rx_data, rx_exp[rx_exp_rd]);
          rx_exp_rd++;
        end
      end
      iocs_prev = bus.iocs; rd_prev = rd;
      req_a_prev = req_a; req_b_prev = req_b; rda_prev = bus.rda;
    end
    check("cfg_drained", cfg_wr - cfg_rd, 0);
    check("tx_a_drained", exp_a_wr - exp_a_rd, 0);
    check("tx_b_drained", exp_b_wr - exp_b_rd, 0);
    check("rx_drained", rx_exp_wr - rx_exp_rd, 0);
    check("timeouts", timeouts, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- stimulus ----------------
  task automatic push_cfg(input logic [1:0] c);
    logic [15:0] d;
    d = exp_div(c);
    cfg_exp_addr[cfg_wr] = 2'b10; cfg_exp_data[cfg_wr] = d[7:0];
    cfg_exp_addr[cfg_wr + 1] = 2'b11; cfg_exp_data[cfg_wr + 1] = d[15:8];
    cfg_wr += 2;
  endtask

  task automatic wait_cfg(input logic level);
    int n = 0;
    while (cfg_done !== level && n < 200) begin @(posedge clk); n++; end
    if (cfg_done !== level) timeouts++;
  endtask

  task automatic add_tx(input int n);
    for (int i = 0; i < n; i++) begin
      src_a[src_a_n] = 8'($urandom); src_a_n++;
      src_b[src_b_n] = 8'($urandom); src_b_n++;
    end
  endtask

  task automatic add_rx(input int n);
    for (int i = 0; i < n; i++) begin
      rx_src[rx_src_n] = 8'($urandom); rx_src_n++;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (n < 3000 && !(a_idx == src_a_n && b_idx == src_b_n && rx_idx == rx_src_n &&
           exp_a_rd == exp_a_wr && exp_b_rd == exp_b_wr && rx_exp_rd == rx_exp_wr &&
           cfg_rd == cfg_wr && cfg_done)) begin
      @(posedge clk); n++;
    end
    if (n >= 3000) timeouts++;
  endtask

  initial begin
    int n;
    // Reset with 19200 selected, then the divisor writes A2 / 00.
    repeat (3) @(posedge clk);
    #1;
    push_cfg(2'b10);
    rst = 1'b1;
    wait_cfg(1'b1);

    // Two received bytes.
    rx_src[0] = 8'hA5; rx_src[1] = 8'hE7; rx_src_n = 2;
    drain();

    // Both requesters held continuously: strict alternation 11,22,11,22.
    src_a[0] = 8'h11; src_a[1] = 8'h11; src_a_n = 2;
    src_b[0] = 8'h22; src_b[1] = 8'h22; src_b_n = 2;
    drain();

    // Randomized mixed traffic with a reconfiguration to 38400 mid-stream.
    gap_max = 3;
    add_tx(12);
    add_rx(6);
    repeat (40) @(posedge clk);
    #2;
    push_cfg(2'b11);
    br_cfg = 2'b11;
    wait_cfg(1'b0);
    wait_cfg(1'b1);
    drain();

    // Reset asserted in the middle of a transmit write.
    add_tx(8);
    add_rx(4);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!(bus.iocs && !bus.iorw && bus.ioaddr == 2'b00) && n < 500);
    if (n >= 500) timeouts++;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    push_cfg(br_cfg);
    rst = 1'b1;
    wait_cfg(1'b1);
    drain();

    repeat (5) @(posedge clk);
    done = 1'b1;
  end

endmodule
